// File: rtl/glossy_round_sched_if.sv
// Handshake and status bundle between glossy_round_sched and its
// controller: enable/config in, start/role/status out.
interface glossy_round_sched_if #(
    parameter int CNT_W = 24
);
    logic             i_enable;
    logic             i_initiator;
    logic [CNT_W-1:0] i_period;
    logic [CNT_W-1:0] i_timeout;
    logic             i_done;
    logic             o_start;
    logic             o_mode;
    logic             o_busy;
    logic             o_timeout;
    logic [7:0]       o_round_cnt;
    logic [7:0]       o_timeout_cnt;

    modport master (
        output i_enable,
        output i_initiator,
        output i_period,
        output i_timeout,
        output i_done,
        input  o_start,
        input  o_mode,
        input  o_busy,
        input  o_timeout,
        input  o_round_cnt,
        input  o_timeout_cnt
    );

    modport slave (
        input  i_enable,
        input  i_initiator,
        input  i_period,
        input  i_timeout,
        input  i_done,
        output o_start,
        output o_mode,
        output o_busy,
        output o_timeout,
        output o_round_cnt,
        output o_timeout_cnt
    );
endinterface

// File: rtl/glossy_round_sched.sv
// glossy_round_sched: periodic start/role generator for glossy_app floods,
// counting completed rounds and detecting rounds that miss their deadline.
module glossy_round_sched #(
    parameter int CNT_W      = 24,
    parameter int MIN_PERIOD = 4
) (
    input  logic                clk,
    input  logic                reset,
    glossy_round_sched_if.slave sif
);
    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE,
        WAIT_PERIOD
    } state_t;

    localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] per_q;
    logic [CNT_W-1:0] tmo_q;
    logic [CNT_W-1:0] per_new;
    logic [CNT_W-1:0] per_m1_new;
    logic [CNT_W-1:0] tmo_new;
    logic             done_q;
    logic             mode_q;
    logic             to_q;
    logic [7:0]       round_q;
    logic [7:0]       tocnt_q;
    logic             run;
    logic             done_edge;
    logic             per_end;
    logic             latch_cfg;
    logic             round_inc;
    logic             to_hit;

    always_comb begin
        run        = sif.i_enable;
        per_new    = (sif.i_period < MIN_P) ? MIN_P : sif.i_period;
        per_m1_new = per_new - ONE;
        tmo_new    = (sif.i_timeout < per_m1_new) ? sif.i_timeout
                                                  : per_m1_new;
        done_edge  = sif.i_done & ~done_q;
        per_end    = (cnt_q == per_q - ONE);
    end

    always_comb begin
        state_d   = state_q;
        latch_cfg = 1'b0;
        round_inc = 1'b0;
        to_hit    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (run) begin
                    latch_cfg = 1'b1;
                    state_d   = START;
                end
            end
            START: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                // a deadline equal to per-1 ends the round on the
                // last cycle of the period, so restart directly
                if (done_edge) begin
                    round_inc = 1'b1;
                    state_d   = per_end ? START : WAIT_PERIOD;
                end else if (cnt_q >= tmo_q) begin
                    to_hit  = 1'b1;
                    state_d = per_end ? START : WAIT_PERIOD;
                end
            end
            WAIT_PERIOD: begin
                if (per_end) state_d = START;
            end
            default: state_d = IDLE;
        endcase
        if (!run && state_q != IDLE) begin
            state_d   = IDLE;
            round_inc = 1'b0;
            to_hit    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
            tmo_q   <= '0;
            done_q  <= 1'b0;
            mode_q  <= 1'b0;
            to_q    <= 1'b0;
            round_q <= '0;
            tocnt_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= sif.i_done;
            to_q    <= to_hit;
            if (latch_cfg) begin
                per_q   <= per_new;
                tmo_q   <= tmo_new;
                round_q <= '0;
                tocnt_q <= '0;
            end else begin
                if (round_inc) round_q <= round_q + 8'd1;
                if (to_hit && tocnt_q != 8'hFF) tocnt_q <= tocnt_q + 8'd1;
            end
            if (state_d == START) begin
                cnt_q  <= '0;
                mode_q <= sif.i_initiator;
            end else if (state_d != IDLE) begin
                cnt_q <= cnt_q + ONE;
            end
        end
    end

    always_comb begin
        sif.o_start       = (state_q == START) & run;
        sif.o_busy        = (state_q == START || state_q == WAIT_DONE) & run;
        sif.o_timeout     = to_q & run;
        sif.o_mode        = mode_q;
        sif.o_round_cnt   = round_q;
        sif.o_timeout_cnt = tocnt_q;
    end
endmodule
